// File: rtl/snn_run_controller_pkg.sv
// Shared types and helpers for the SNN run controller: run-state encoding and
// a width-generic saturating increment used by the spike counters.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Increments v, holding at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/snn_run_controller_if.sv
// Input spike stream handshake plus host weight-memory bus of the run controller.
// master = host / spike source side, slave = controller side.
interface snn_run_controller_if #(
  parameter int NUM_INPUTS       = 4,
  parameter int WEIGHT_SIZE      = 32,
  parameter int LAYER_ADDR_WIDTH = 32
);
  logic                        in_valid;
  logic [NUM_INPUTS-1:0]       in_spikes;
  logic                        in_ready;
  logic [LAYER_ADDR_WIDTH-1:0] host_addr;
  logic [WEIGHT_SIZE-1:0]      host_din;
  logic                        host_wen;
  logic [WEIGHT_SIZE-1:0]      host_dout;
  logic                        host_err;

  modport master (
    output in_valid, in_spikes, host_addr, host_din, host_wen,
    input  in_ready, host_dout, host_err
  );

  modport slave (
    input  in_valid, in_spikes, host_addr, host_din, host_wen,
    output in_ready, host_dout, host_err
  );
endinterface

// File: rtl/snn_run_controller_spike_counter_bank.sv
// Per-neuron saturating spike counters with clear and sample enable.
// With SNN_RUN_WINNER_EN defined it also registers the argmax of the counts.
module snn_spike_counter_bank
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_OUTPUTS = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               sample_en,
  input  logic [NUM_OUTPUTS-1:0]             spikes,
  output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] count
`ifdef SNN_RUN_WINNER_EN
  ,
  input  logic                               win_load,
  output logic [((NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1)-1:0] win_idx
`endif
);

  logic [COUNT_WIDTH-1:0] cnt_q [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_OUTPUTS];

  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr)
        cnt_d[i] = '0;
      else if (sample_en && spikes[i])
        cnt_d[i] = COUNT_WIDTH'(sat_inc(64'(cnt_q[i]), COUNT_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_pack
    assign count[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[g];
  end

`ifdef SNN_RUN_WINNER_EN
  localparam int WIN_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  logic [WIN_W-1:0]       best_idx;
  logic [COUNT_WIDTH-1:0] best_cnt;
  logic [WIN_W-1:0]       win_q;

  // Argmax is taken over next-state counts so the final DRAIN sample is included;
  // strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_cnt = cnt_d[0];
    for (int i = 1; i < NUM_OUTPUTS; i++) begin
      if (cnt_d[i] > best_cnt) begin
        best_cnt = cnt_d[i];
        best_idx = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           win_q <= '0;
    else if (win_load) win_q <= best_idx;
  end

  assign win_idx = win_q;
`endif

endmodule

// File: rtl/snn_run_controller.sv
// Sequences one recurrent IF network inference run and arbitrates host weight access.
// Optional feature macro: SNN_RUN_WINNER_EN (adds winner_idx / winner_valid).
module snn_run_controller
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS       = 4,
  parameter int NUM_OUTPUTS      = 1,
  parameter int NUM_TIMESTEPS    = 100,
  parameter int COUNT_WIDTH      = 16,
  parameter int WEIGHT_SIZE      = 32,
  parameter int LAYER_ADDR_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  snn_run_controller_if.slave                ctrl,
  output logic                               net_rst,
  output logic [NUM_INPUTS-1:0]              net_spike_in,
  input  logic [NUM_OUTPUTS-1:0]             net_spike_out,
  output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] spike_count,
  output logic [LAYER_ADDR_WIDTH-1:0]        mem_addr,
  output logic [WEIGHT_SIZE-1:0]             mem_din,
  output logic                               mem_wen,
  input  logic [WEIGHT_SIZE-1:0]             mem_dout
`ifdef SNN_RUN_WINNER_EN
  ,
  output logic [((NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1)-1:0] winner_idx,
  output logic                               winner_valid
`endif
);

  localparam int              TS_W    = $clog2(NUM_TIMESTEPS + 1);
  localparam logic [TS_W-1:0] TS_LAST = TS_W'(NUM_TIMESTEPS - 1);

  state_e          state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            sample_q, done_q, err_q;
  logic            hs, clr, win_load;

  assign hs = ctrl.in_valid & ctrl.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      sample_q <= hs;
      done_q   <= (state_q == DRAIN);
      err_q    <= ctrl.host_wen & busy;
    end
  end

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = RUN;
        ts_d    = '0;
      end
      RUN: begin
        if (hs) begin
          ts_d = ts_q + TS_W'(1);
          if (ts_q == TS_LAST) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    ctrl.in_ready = 1'b0;
    clr           = 1'b0;
`ifdef SNN_RUN_WINNER_EN
    winner_valid  = 1'b0;
`endif
    case (state_q)
      CLEAR: begin
        busy = 1'b1;
        clr  = 1'b1;
      end
      RUN: begin
        busy          = 1'b1;
        ctrl.in_ready = 1'b1;
      end
      DRAIN: busy = 1'b1;
`ifdef SNN_RUN_WINNER_EN
      DONE:  winner_valid = 1'b1;
`endif
      default: ;
    endcase
  end

  assign win_load       = (state_q == DRAIN);
  assign done           = done_q;
  assign net_rst        = rst | clr;
  assign net_spike_in   = hs ? ctrl.in_spikes : '0;

  // Host port: reads always pass through, writes are gated off for the whole run.
  assign mem_addr       = ctrl.host_addr;
  assign mem_din        = ctrl.host_din;
  assign mem_wen        = ctrl.host_wen & ~busy;
  assign ctrl.host_dout = mem_dout;
  assign ctrl.host_err  = err_q;

  snn_spike_counter_bank #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .sample_en (sample_q),
    .spikes    (net_spike_out),
    .count     (spike_count)
`ifdef SNN_RUN_WINNER_EN
    ,
    .win_load  (win_load),
    .win_idx   (winner_idx)
`endif
  );

`ifndef SNN_RUN_WINNER_EN
  logic unused_win_load;
  assign unused_win_load = win_load;
`endif

endmodule
